// File: rtl/digit_entry_ctrl_pkg.sv
// Shared constants and types for the PS/2 digit entry sequencer:
// scan-code values, digit/keypad tables, FSM state encoding and key classes.
package digit_entry_ctrl_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;

   // Index i of each table is the scan code for digit i.
   localparam logic [7:0] DIGIT_SC [10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
   };
   localparam logic [7:0] KEYPAD_SC [10] = '{
      8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
   };

   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE      = 2'd0;
   localparam fsm_state_t ST_BREAK     = 2'd1;
   localparam fsm_state_t ST_EXT       = 2'd2;
   localparam fsm_state_t ST_EXT_BREAK = 2'd3;

   typedef enum logic [1:0] {
      CLS_NONE,
      CLS_DIGIT,
      CLS_BKSP,
      CLS_ENTER
   } key_class_t;

endpackage

// File: rtl/digit_entry_ctrl_if.sv
// Byte-receiver input and digit-register-bank output bundle of digit_entry_ctrl.
// master = byte source / register bank side, slave = the sequencer.
interface digit_entry_ctrl_if #(
   parameter int NREG = 4,
   parameter int N    = 5,
   parameter int PW   = $clog2(NREG + 1)
);
   logic            rx_done;
   logic [7:0]      rx_data;
   logic [NREG-1:0] load;
   logic [N-1:0]    d_out;
   logic [PW-1:0]   ptr;
   logic            full;
   logic            entry_done;

   modport master (
      output rx_done, rx_data,
      input  load, d_out, ptr, full, entry_done
   );

   modport slave (
      input  rx_done, rx_data,
      output load, d_out, ptr, full, entry_done
   );
endinterface

// File: rtl/digit_entry_ctrl_scan_decode.sv
// Combinational classifier for a released (non-extended) key byte.
// Keypad digits are recognised only when DIGIT_ENTRY_KEYPAD_EN is defined.
module scan_decode
   import digit_entry_ctrl_pkg::*;
(
   input  logic [7:0] code,
   output key_class_t cls,
   output logic [3:0] digit
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      cls   = CLS_NONE;
      digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (code == DIGIT_SC[i]) begin
            cls   = CLS_DIGIT;
            digit = 4'(i);
         end
`ifdef DIGIT_ENTRY_KEYPAD_EN
         if (code == KEYPAD_SC[i]) begin
            cls   = CLS_DIGIT;
            digit = 4'(i);
         end
`endif
      end
      if (code == SC_BKSP)  cls = CLS_BKSP;
      if (code == SC_ENTER) cls = CLS_ENTER;
   end

endmodule

// File: rtl/digit_entry_ctrl.sv
// PS/2 scan-code sequencer that writes digits into a bank of NREG registers on key release.
// Optional macro DIGIT_ENTRY_KEYPAD_EN also accepts numeric keypad digits.
module digit_entry_ctrl
   import digit_entry_ctrl_pkg::*;
#(
   parameter int             NREG      = 4,
   parameter int             N         = 5,
   parameter logic [N-1:0]   CLEAR_VAL = N'(5'h1F),
   localparam int            PW        = $clog2(NREG + 1)
) (
   input logic               clk,
   input logic               rst,
   digit_entry_ctrl_if.slave bus
);

   fsm_state_t      state;
   logic [PW-1:0]   ptr_q;
   logic [NREG-1:0] load_q;
   logic [N-1:0]    d_q;
   logic            done_q;

   key_class_t      dec_cls;
   key_class_t      act_cls;
   logic [3:0]      dec_digit;

   scan_decode u_dec (
      .code  (bus.rx_data),
      .cls   (dec_cls),
      .digit (dec_digit)
   );

   // Only a byte that completes a break sequence can act; extended releases act only as Enter.
   always_comb begin
      act_cls = CLS_NONE;
      if (bus.rx_done) begin
         if (state == ST_BREAK)
            act_cls = dec_cls;
         else if (state == ST_EXT_BREAK && bus.rx_data == SC_ENTER)
            act_cls = CLS_ENTER;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         ptr_q  <= '0;
         load_q <= '0;
         d_q    <= '0;
         done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update ordered as on real flops.
         load_q <= '0;
         done_q <= 1'b0;

         if (bus.rx_done) begin
            case (state)
               ST_IDLE: begin
                  if (bus.rx_data == SC_BREAK)    state <= ST_BREAK;
                  else if (bus.rx_data == SC_EXT) state <= ST_EXT;
               end
               ST_EXT:  state <= (bus.rx_data == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end

         case (act_cls)
            CLS_DIGIT: begin
               if (ptr_q != PW'(NREG)) begin
                  load_q <= NREG'(1) << ptr_q;
                  d_q    <= N'(dec_digit);
                  ptr_q  <= ptr_q + PW'(1);
               end
            end
            CLS_BKSP: begin
               if (ptr_q != '0) begin
                  load_q <= NREG'(1) << (ptr_q - PW'(1));
                  d_q    <= CLEAR_VAL;
                  ptr_q  <= ptr_q - PW'(1);
               end
            end
            CLS_ENTER: begin
               if (ptr_q != '0) begin
                  done_q <= 1'b1;
                  ptr_q  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.load       = load_q;
   assign bus.d_out      = d_q;
   assign bus.ptr        = ptr_q;
   assign bus.full       = (ptr_q == PW'(NREG));
   assign bus.entry_done = done_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Self-checking bench for digit_entry_ctrl: directed test-plan sequences followed by
// randomized byte streams, compared against a queue-based model of the keyboard protocol.
module tb_digit_entry_ctrl;

   localparam int           NREG      = 4;
   localparam int           N         = 5;
   localparam int           PW        = $clog2(NREG + 1);
   localparam logic [N-1:0] CLEAR_VAL = 5'h1F;

   logic clk = 1'b0;
   logic rst = 1'b1;

   digit_entry_ctrl_if #(.NREG(NREG), .N(N), .PW(PW)) bus ();

   digit_entry_ctrl #(.NREG(NREG), .N(N), .CLEAR_VAL(CLEAR_VAL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] kp_sc  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

   // Model: count of entered digits, register contents, and bytes of an unfinished prefix.
   int              ent = 0;
   logic [N-1:0]    m_regs [NREG];
   logic [N-1:0]    bank   [NREG];
   logic [7:0]      pend [$];
   logic [NREG-1:0] exp_load = '0;
   logic [N-1:0]    exp_d    = '0;
   logic            exp_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int digit_of(input logic [7:0] b);
      for (int i = 0; i < 10; i++) begin
         if (b == dig_sc[i]) return i;
`ifdef DIGIT_ENTRY_KEYPAD_EN
         if (b == kp_sc[i]) return i;
`endif
      end
      return -1;
   endfunction

   task automatic release_key(input logic [7:0] b, input bit ext);
      int d;
      d = ext ? -1 : digit_of(b);
      if (d >= 0) begin
         if (ent < NREG) begin
            exp_load    = NREG'(1) << ent;
            exp_d       = N'(d);
            m_regs[ent] = N'(d);
            ent++;
         end
      end else if (!ext && b == 8'h66) begin
         if (ent > 0) begin
            ent--;
            exp_load    = NREG'(1) << ent;
            exp_d       = CLEAR_VAL;
            m_regs[ent] = CLEAR_VAL;
         end
      end else if (b == 8'h5A) begin
         if (ent > 0) begin
            exp_done = 1'b1;
            ent      = 0;
         end
      end
   endtask

   // A key event is F0 x, E0 x, or E0 F0 x; anything else is a make code and is dropped.
   task automatic model_byte(input logic [7:0] b);
      pend.push_back(b);
      if (pend.size() == 1) begin
         if (b != 8'hF0 && b != 8'hE0) pend.delete();
      end else if (pend.size() == 2) begin
         if (pend[0] == 8'hF0) begin
            release_key(b, 1'b0);
            pend.delete();
         end else if (b != 8'hF0) begin
            pend.delete();
         end
      end else begin
         release_key(b, 1'b1);
         pend.delete();
      end
   endtask

   task automatic check_outputs(input string ctx);
      check({ctx, "_load"},       32'(bus.load),       32'(exp_load));
      check({ctx, "_d_out"},      32'(bus.d_out),      32'(exp_d));
      check({ctx, "_ptr"},        32'(bus.ptr),        32'(ent));
      check({ctx, "_full"},       32'(bus.full),       32'(ent == NREG));
      check({ctx, "_entry_done"}, 32'(bus.entry_done), 32'(exp_done));
      for (int i = 0; i < NREG; i++)
         if (bus.load[i] === 1'b1) bank[i] = bus.d_out;
   endtask

   // Called at a falling edge: present one cycle of input, then check after the rising edge.
   task automatic step(input logic v, input logic [7:0] b, input string ctx = "step");
      bus.rx_done = v;
      bus.rx_data = b;
      exp_load    = '0;
      exp_done    = 1'b0;
      if (v) model_byte(b);
      @(negedge clk);
      check_outputs(ctx);
   endtask

   task automatic do_reset(input logic [7:0] b);
      rst         = 1'b1;
      bus.rx_done = 1'b1;
      bus.rx_data = b;
      @(negedge clk);
      ent      = 0;
      pend.delete();
      exp_load = '0;
      exp_d    = '0;
      exp_done = 1'b0;
      check_outputs("reset");
      rst         = 1'b0;
      bus.rx_done = 1'b0;
   endtask

   task automatic release_seq(input logic [7:0] code, input string ctx);
      step(1'b1, 8'hF0, ctx);
      step(1'b1, code, ctx);
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 9))
         0, 1, 2: return 8'hF0;
         3:       return 8'hE0;
         4, 5:    return dig_sc[$urandom_range(0, 9)];
         6:       return 8'h66;
         7:       return 8'h5A;
         8:       return kp_sc[$urandom_range(0, 9)];
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         bank[i]   = '0;
      end

      // Reset with rx_done high: reset must win.
      do_reset(8'hF0);

      // Make code alone does nothing; release of "1" loads bit 0.
      step(1'b1, 8'h16, "make_only");
      step(1'b0, 8'h00, "idle");
      release_seq(8'h16, "rel_1");
      step(1'b0, 8'h00, "rel_1_after");

      // Fill to NREG, then one more digit is ignored.
      release_seq(8'h1E, "rel_2");
      release_seq(8'h26, "rel_3");
      release_seq(8'h25, "rel_4");
      release_seq(8'h2E, "rel_5_full");
      step(1'b0, 8'h00, "full_idle");

      // Backspaces down to empty, then one more at ptr=0.
      release_seq(8'h66, "bksp_a");
      release_seq(8'h66, "bksp_b");
      release_seq(8'h66, "bksp_c");
      release_seq(8'h66, "bksp_d");
      release_seq(8'h66, "bksp_empty");

      // Extended Enter commits; plain Enter at ptr=0 does nothing.
      release_seq(8'h45, "pre_enter_a");
      release_seq(8'h36, "pre_enter_b");
      release_seq(8'h3D, "pre_enter_c");
      step(1'b1, 8'hE0, "ext_enter");
      step(1'b1, 8'hF0, "ext_enter");
      step(1'b1, 8'h5A, "ext_enter");
      step(1'b0, 8'h00, "ext_enter_after");
      release_seq(8'h5A, "enter_empty");

      // Extended make ignored, then a real release of "0".
      step(1'b1, 8'hE0, "ext_make");
      step(1'b1, 8'h75, "ext_make");
      release_seq(8'h45, "rel_0");

      // Reset between F0 and the code byte drops the prefix.
      step(1'b1, 8'hF0, "pre_reset");
      do_reset(8'($urandom));
      step(1'b1, 8'h16, "after_reset_make");

      // Keypad "1".
      release_seq(8'h69, "keypad_1");

      // Randomized streams with idle gaps, back-to-back bytes and occasional resets.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 63) == 0)
            do_reset(pick());
         else
            step(($urandom_range(0, 3) != 0), pick(), "rand");
      end

      for (int i = 0; i < NREG; i++)
         check($sformatf("bank_%0d", i), 32'(bank[i]), 32'(m_regs[i]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/digit_entry_ctrl.md
Name: digit_entry_ctrl

Overview:
- Sequencer between the PS/2 byte receiver and a bank of NREG N-bit digit holding registers (load-enable registers, one per displayed digit).
- Parses make/break/extended scan-code bytes and acts on key release only, so typematic repeats never produce writes.
- Issues one-hot load strobes plus write data, maintains the entry pointer, and handles backspace and enter.

Parameters:
- NREG, 4, number of digit registers sequenced (2..8).
- N, 5, digit code width; must be >= 4 and wide enough to hold CLEAR_VAL.
- CLEAR_VAL, 5'h1F, code written on backspace (blank digit).
- PW, $clog2(NREG+1), pointer width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- rx_done  in  1  one-cycle strobe: rx_data holds a new scan-code byte
- rx_data  in  8  received scan-code byte
- load  out  NREG  one-hot load strobes to the digit registers (registered)
- d_out  out  N  write data to the digit registers, valid while any load bit is high (registered)
- ptr  out  PW  number of digits entered, 0..NREG
- full  out  1  high when ptr == NREG
- entry_done  out  1  one-cycle pulse when an entry is committed by Enter

Behaviour:
- Reset and clocking:
  - Single clock clk; reset rst is synchronous and active-high.
  - On reset: state=IDLE, ptr=0, load=0, d_out=0, entry_done=0, full=0, ext flag=0.
  - rst dominates rx_done in the same cycle. Reset mid-sequence discards any pending F0/E0 prefix.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK. Transitions occur only on cycles with rx_done=1.
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte is a make code and is ignored (stay IDLE).
  - EXT: F0 -> EXT_BREAK; any other byte -> IDLE (extended make is ignored).
  - BREAK: any byte -> IDLE, and the byte is classified as a released key.
  - EXT_BREAK: any byte -> IDLE; only 5A is classified (Enter); all others are ignored.
- Classification of the released key (non-extended):
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - 66 = Backspace. 5A = Enter. Anything else is ignored.
- Actions. The action register is updated in the cycle after the rx_done byte (latency 1), and load/entry_done are high for exactly one cycle.
  - Digit, ptr<NREG: load[ptr]=1, d_out=digit code, ptr<=ptr+1.
  - Digit, ptr==NREG: ignored. No load, ptr unchanged (no wrap-around).
  - Backspace, ptr>0: load[ptr-1]=1, d_out=CLEAR_VAL, ptr<=ptr-1.
  - Backspace, ptr==0: ignored.
  - Enter, ptr>0: entry_done=1, ptr<=0. Register contents are not cleared.
  - Enter, ptr==0: ignored.
- Output invariants:
  - full is combinational from ptr.
  - At most one load bit is high in any cycle.
  - d_out holds its last value when load=0.
- An rx_done may arrive on consecutive cycles; each byte is processed in its own cycle with no loss.

Optional Feature:
- Macro: DIGIT_ENTRY_KEYPAD_EN.
- Defined: numeric keypad releases are also classified as digits: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
- Undefined: these codes are ignored like any other unknown key.

Decomposition:
- Shared package holds:
  - Scan-code constants SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66, and the digit and keypad code tables.
  - FSM state encoding typedef.
  - Class encoding typedef: NONE, DIGIT, BKSP, ENTER.
- One sub-module: scan_decode. Purely combinational byte -> {class, digit value}, honouring DIGIT_ENTRY_KEYPAD_EN. The FSM, pointer and output registers stay in the top module.

Test Plan:
- Reset, then bytes 16, F0, 16 -> load=0001 and d_out=1 one cycle after the third byte; ptr=1; the make byte 16 alone produces no load.
- Release keys 1,2,3,4 (NREG=4) then 5 -> loads 0001, 0010, 0100, 1000 with d_out 1,2,3,4; full=1; the fifth release gives no load and ptr stays 4.
- ptr=2, then F0 66 -> load=0010, d_out=1F, ptr=1. A further two backspaces give one load at bit 0, then nothing; ptr=0.
- ptr=3, then E0 F0 5A -> entry_done pulses once, ptr=0, no load. F0 5A at ptr=0 -> no pulse.
- E0 75 (extended make), then F0 45 -> only the second sequence acts: load[ptr], d_out=0. rst asserted between F0 and the code byte -> the prefix is dropped and the following code byte is treated as a make code.
- Keypad release F0 69: with DIGIT_ENTRY_KEYPAD_EN defined -> load and d_out=1; without it -> no load.
